// File: rtl/imem_byte_rom_if.sv
// Loader and fetch port bundle for imem_byte_rom.
// The slave side is the memory; the master side is the PC/loader.
interface imem_byte_rom_if #(
  parameter int ADDR_W     = 9,
  parameter int WORD_BYTES = 4
) ();
  logic                    load_start;
  logic                    load_valid;
  logic [7:0]              load_byte;
  logic                    load_last;
  logic [ADDR_W:0]         load_count;
  logic                    load_overflow;
  logic                    rd_ready;
  logic                    rd_req;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_valid;
  logic [8*WORD_BYTES-1:0] rd_data;
  logic                    rd_misaligned;

  modport slave (
    input  load_start, load_valid, load_byte, load_last,
    input  rd_req, rd_addr,
    output load_count, load_overflow,
    output rd_ready, rd_valid, rd_data, rd_misaligned
  );

  modport master (
    output load_start, load_valid, load_byte, load_last,
    output rd_req, rd_addr,
    input  load_count, load_overflow,
    input  rd_ready, rd_valid, rd_data, rd_misaligned
  );
endinterface

// File: rtl/imem_byte_rom.sv
// Byte-addressed instruction memory with byte-serial loader
// and a registered one-cycle word fetch.
module imem_byte_rom #(
  parameter int ADDR_W     = 9,
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic            clk,
  input  logic            clr,
  imem_byte_rom_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW    = 8 * WORD_BYTES;
  localparam logic [ADDR_W:0] FULL =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] AMASK =
    ADDR_W'(WORD_BYTES - 1);

  typedef enum logic {LOAD, RUN} state_e;

  logic [7:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            vld_q, vld_d;
  logic [DW-1:0]   data_q, data_d;
  logic            mis_q, mis_d;
  logic            we;

  logic [DW-1:0]     word_c;
  logic [ADDR_W-1:0] a_c;
  logic [7:0]        b_c;

  // Bytes past the loaded region read as zero, never stale data
  always_comb begin
    word_c = '0;
    a_c    = '0;
    b_c    = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      a_c = bus.rd_addr + ADDR_W'(k);
      b_c = ({1'b0, a_c} < cnt_q) ? mem[a_c] : 8'h00;
      if (BIG_ENDIAN != 0)
        word_c[8*(WORD_BYTES-1-k) +: 8] = b_c;
      else
        word_c[8*k +: 8] = b_c;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    mis_d   = mis_q;
    we      = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (bus.load_valid) begin
          if (cnt_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
          if (bus.load_last)
            state_d = RUN;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (bus.rd_req) begin
          vld_d  = 1'b1;
          data_d = word_c;
          mis_d  = |(bus.rd_addr & AMASK);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
    end
  end

  // Array is deliberately not reset; writes are blocked while clr is held
  always_ff @(posedge clk) begin
    if (we && clr)
      mem[cnt_q[ADDR_W-1:0]] <= bus.load_byte;
  end

  assign bus.load_count    = cnt_q;
  assign bus.load_overflow = ovf_q;
  assign bus.rd_ready      = (state_q == RUN);
  assign bus.rd_valid      = vld_q;
  assign bus.rd_data       = data_q;
  assign bus.rd_misaligned = mis_q;
endmodule

// File: tb/tb_imem_byte_rom.sv
// Three imem_byte_rom variants share one stimulus stream and
// are compared against a byte-array reference model.
module tb_imem_byte_rom;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  imem_byte_rom_if #(.ADDR_W(9), .WORD_BYTES(4)) be_if ();
  imem_byte_rom_if #(.ADDR_W(9), .WORD_BYTES(4)) le_if ();
  imem_byte_rom_if #(.ADDR_W(3), .WORD_BYTES(4)) sm_if ();

  assign le_if.load_start = be_if.load_start;
  assign le_if.load_valid = be_if.load_valid;
  assign le_if.load_byte  = be_if.load_byte;
  assign le_if.load_last  = be_if.load_last;
  assign le_if.rd_req     = be_if.rd_req;
  assign le_if.rd_addr    = be_if.rd_addr;
  assign sm_if.load_start = be_if.load_start;
  assign sm_if.load_valid = be_if.load_valid;
  assign sm_if.load_byte  = be_if.load_byte;
  assign sm_if.load_last  = be_if.load_last;
  assign sm_if.rd_req     = be_if.rd_req;
  assign sm_if.rd_addr    = be_if.rd_addr[2:0];

  imem_byte_rom #(.ADDR_W(9), .WORD_BYTES(4), .BIG_ENDIAN(1))
    u_be (.clk(clk), .clr(clr), .bus(be_if));
  imem_byte_rom #(.ADDR_W(9), .WORD_BYTES(4), .BIG_ENDIAN(0))
    u_le (.clk(clk), .clr(clr), .bus(le_if));
  imem_byte_rom #(.ADDR_W(3), .WORD_BYTES(4), .BIG_ENDIAN(1))
    u_sm (.clk(clk), .clr(clr), .bus(sm_if));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  bit [7:0]  mem_b [512];
  bit [7:0]  mem_s [8];
  int        cnt_b, cnt_s;
  bit        ovf_b, ovf_s, run;
  bit        exp_v, exp_mis;
  bit [31:0] exp_be, exp_le, exp_sm;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h @%0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic bit [31:0] ref_word(bit sm, int addr, bit big);
    bit [31:0] w = '0;
    int d = sm ? 8 : 512;
    for (int k = 0; k < 4; k++) begin
      int a = (addr + k) % d;
      bit [7:0] b = 8'h00;
      if (a < (sm ? cnt_s : cnt_b))
        b = sm ? mem_s[a] : mem_b[a];
      if (big) w[8*(3-k) +: 8] = b;
      else     w[8*k +: 8] = b;
    end
    return w;
  endfunction

  task automatic model_reset();
    cnt_b = 0; cnt_s = 0; ovf_b = 0; ovf_s = 0; run = 0;
    exp_v = 0; exp_mis = 0; exp_be = 0; exp_le = 0; exp_sm = 0;
  endtask

  task automatic check_outs(input string p);
    chk({p, "_ready"}, be_if.rd_ready, run);
    chk({p, "_ready_s"}, sm_if.rd_ready, run);
    chk({p, "_valid"}, be_if.rd_valid, exp_v);
    chk({p, "_valid_le"}, le_if.rd_valid, exp_v);
    chk({p, "_valid_s"}, sm_if.rd_valid, exp_v);
    chk({p, "_cnt_b"}, be_if.load_count, cnt_b);
    chk({p, "_cnt_le"}, le_if.load_count, cnt_b);
    chk({p, "_cnt_s"}, sm_if.load_count, cnt_s);
    chk({p, "_ovf_b"}, be_if.load_overflow, ovf_b);
    chk({p, "_ovf_s"}, sm_if.load_overflow, ovf_s);
    chk({p, "_data_be"}, be_if.rd_data, exp_be);
    chk({p, "_data_le"}, le_if.rd_data, exp_le);
    chk({p, "_data_s"}, sm_if.rd_data, exp_sm);
    chk({p, "_mis"}, be_if.rd_misaligned, exp_mis);
    chk({p, "_mis_s"}, sm_if.rd_misaligned, exp_mis);
  endtask

  task automatic tick();
    @(posedge clk);
    exp_v = 0;
    if (!run) begin
      if (be_if.load_valid) begin
        if (cnt_b < 512) begin
          mem_b[cnt_b] = be_if.load_byte; cnt_b++;
        end else ovf_b = 1;
        if (cnt_s < 8) begin
          mem_s[cnt_s] = be_if.load_byte; cnt_s++;
        end else ovf_s = 1;
        if (be_if.load_last) run = 1;
      end
    end else if (be_if.load_start) begin
      run = 0; cnt_b = 0; cnt_s = 0; ovf_b = 0; ovf_s = 0;
    end else if (be_if.rd_req) begin
      exp_v   = 1;
      exp_be  = ref_word(0, int'(be_if.rd_addr), 1);
      exp_le  = ref_word(0, int'(be_if.rd_addr), 0);
      exp_sm  = ref_word(1, int'(be_if.rd_addr), 1);
      exp_mis = (be_if.rd_addr % 4) != 0;
    end
    #1;
    check_outs("cyc");
  endtask

  task automatic idle_in();
    be_if.load_start = 0; be_if.load_valid = 0;
    be_if.load_byte  = 0; be_if.load_last  = 0;
    be_if.rd_req     = 0; be_if.rd_addr    = 0;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit last);
    be_if.load_valid = 1; be_if.load_byte = b;
    be_if.load_last  = last;
    tick();
    be_if.load_valid = 0; be_if.load_last = 0;
  endtask

  task automatic rd(input int addr);
    be_if.rd_req = 1; be_if.rd_addr = 9'(addr);
    tick();
    be_if.rd_req = 0;
  endtask

  task automatic restart();
    be_if.load_start = 1;
    tick();
    be_if.load_start = 0;
  endtask

  task automatic do_reset();
    #2 clr = 0;
    #1;
    model_reset();
    check_outs("rst");
    #1 clr = 1;
  endtask

  initial begin
    idle_in();
    model_reset();
    #3;
    check_outs("rst0");
    #4 clr = 1;

    put_byte(8'h8A, 0); put_byte(8'h80, 0);
    put_byte(8'h20, 0); put_byte(8'h01, 1);
    rd(0);
    chk("tp_be_word", be_if.rd_data, 32'h8A802001);
    chk("tp_le_word", le_if.rd_data, 32'h0120808A);
    chk("tp_mis0", be_if.rd_misaligned, 1'b0);
    chk("tp_cnt4", be_if.load_count, 4);
    tick();
    chk("tp_one_pulse", be_if.rd_valid, 1'b0);

    be_if.load_start = 1; be_if.rd_req = 1; be_if.rd_addr = 0;
    tick();
    be_if.load_start = 0; be_if.rd_req = 0;
    chk("tp_ls_valid", be_if.rd_valid, 1'b0);
    chk("tp_ls_ready", be_if.rd_ready, 1'b0);
    chk("tp_ls_cnt", be_if.load_count, 0);

    for (int i = 0; i < 8; i++) put_byte(8'(i), i == 7);
    rd(2);
    chk("tp_mis_word", be_if.rd_data, 32'h02030405);
    chk("tp_mis_flag", be_if.rd_misaligned, 1'b1);
    rd(6);
    chk("tp_unloaded", be_if.rd_data, 32'h06070000);

    restart();
    for (int i = 0; i < 9; i++) put_byte(8'h10 + 8'(i), i == 8);
    rd(6);
    chk("tp_wrap", sm_if.rd_data, 32'h16171011);
    chk("tp_ovf", sm_if.load_overflow, 1'b1);
    chk("tp_sat", sm_if.load_count, 8);
    rd(0); rd(4); rd(8);
    chk("tp_b2b_last", be_if.rd_data, 32'h18000000);

    restart();
    put_byte(8'hAA, 0); put_byte(8'hBB, 0);
    do_reset();
    for (int i = 0; i < 4; i++) put_byte(8'hC0 + 8'(i), i == 3);
    rd(0);
    chk("tp_reload", be_if.rd_data, 32'hC0C1C2C3);

    // reset with a read in flight drops it
    be_if.rd_req = 1; be_if.rd_addr = 1;
    @(posedge clk);
    be_if.rd_req = 0;
    #1 clr = 0;
    #1;
    model_reset();
    check_outs("rst_inflight");
    #1 clr = 1;

    for (int r = 0; r < 8; r++) begin
      int n = (r == 3) ? 515 : int'($urandom_range(1, 24));
      int sent = 0;
      if (run) restart();
      while (sent < n) begin
        be_if.rd_req     = $urandom_range(0, 1);
        be_if.rd_addr    = 9'($urandom);
        be_if.load_start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) != 0) begin
          sent++;
          put_byte(8'($urandom), sent == n);
        end else begin
          be_if.load_last = $urandom_range(0, 1);
          tick();
          be_if.load_last = 0;
        end
        be_if.rd_req = 0; be_if.load_start = 0;
      end
      for (int c = 0; c < 40; c++) begin
        be_if.rd_req     = ($urandom_range(0, 3) != 0);
        be_if.rd_addr    = (c % 5 == 0) ? 9'(508 + c % 4)
                                        : 9'($urandom);
        be_if.load_valid = $urandom_range(0, 1);
        be_if.load_start = ($urandom_range(0, 59) == 0);
        tick();
        idle_in();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_byte_rom.md
# imem_byte_rom

Parametrised, byte-addressed instruction memory for the SPARC pipeline that replaces the fixed 512x8 combinational ROM. It adds an in-band byte-serial program loader, a registered one-cycle read with a request/valid handshake, and a configurable byte order. It sits between the PC register and the IF/ID pipeline register. The loader is driven by the testbench precharge logic, or by a boot block in later phases.

## Interface
Parameters:
- ADDR_W, 9, byte-address width; depth = 2^ADDR_W bytes.
- WORD_BYTES, 4, bytes returned per read; must be ≥1 and a power of two.
- BIG_ENDIAN, 1, 1 puts Mem[a] in the MSB byte of rd_data; 0 puts Mem[a] in the LSB byte.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-low.
- load_start  in  1  in RUN: return to LOAD with the pointer at 0.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  byte to store at the load pointer.
- load_last  in  1  qualifies load_valid; this byte ends the load.
- load_count  out  ADDR_W+1  number of bytes stored since the last load began.
- load_overflow  out  1  sticky; a byte arrived while load_count = depth.
- rd_ready  out  1  high only in RUN.
- rd_req  in  1  read request; accepted when rd_req && rd_ready.
- rd_addr  in  ADDR_W  byte address of the word to read.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  8*WORD_BYTES  fetched word.
- rd_misaligned  out  1  rd_addr of the accepted request was not a multiple of WORD_BYTES.

## Operation
- States: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - Each cycle with load_valid, write load_byte to Mem[load_count] and increment load_count.
  - When load_count = depth, discard the byte, leave load_count unchanged, and set load_overflow.
  - load_valid && load_last moves to RUN on the same edge. That byte is written under the rules above.
  - load_last without load_valid is ignored.
- RUN:
  - An accepted request captures WORD_BYTES bytes at rd_addr+k for k = 0..WORD_BYTES-1. Addresses are taken modulo 2^ADDR_W, so reads wrap past the top of memory.
  - Any byte at address ≥ load_count reads as 8'h00, never X.
  - Bytes are ordered into rd_data according to BIG_ENDIAN.
  - rd_misaligned is registered alongside rd_data. The misaligned read still returns its bytes.
- load_start in RUN moves to LOAD and clears load_count and load_overflow. Memory contents are kept.
  - If rd_req arrives in the same cycle, load_start wins and the request is not accepted.
  - A read accepted on the previous edge still completes.
- Reset clears state to LOAD, load_count to 0, load_overflow to 0, and rd_valid and rd_misaligned to 0. rd_data resets to 0. The memory array is not cleared.
- load_valid, load_start and rd_req are ignored in any state where they are not listed above.

## Timing
- Read latency is 1 cycle: a request accepted at edge N gives rd_valid = 1 and rd_data after edge N.
- rd_valid stays high for exactly one cycle per accepted request.
- Back-to-back requests give one result per cycle. rd_data holds its last value when rd_valid = 0.
- rd_ready goes high on the edge that takes LOAD to RUN, and low on the edge that takes load_start into LOAD.
- A load write at edge N is visible to a read accepted at edge N+1 or later. A read cannot be accepted at edge N, because rd_ready is low in LOAD.
- Asserting clr at any point, including mid-load or with a read in flight, acts immediately:
  - all outputs go to their reset values;
  - the in-flight read is dropped, with no rd_valid.
- load_count saturates at 2^ADDR_W. It never wraps.

## Test plan
- Load: bytes 8A,80,20,01 with load_last on the 4th byte, then read addr 0 → rd_valid one cycle later, rd_data = 32'h8A802001, rd_misaligned = 0, load_count = 4.
- BIG_ENDIAN = 0 with the same load → rd_data = 32'h0120808A.
- Misaligned and wrapped reads, with 8 bytes 00..07 loaded:
  - read addr 2 → 32'h02030405, rd_misaligned = 1;
  - read addr 6 → 32'h06070000 (bytes 8 and 9 are unloaded).
- Wrap with ADDR_W = 3 and a full 8-byte load 10..17:
  - read addr 6 → 32'h16171011;
  - a 9th byte sets load_overflow = 1 and load_count stays 8.
- Back-to-back reads at addrs 0, 4, 8 on consecutive cycles → three consecutive rd_valid pulses with the matching words.
- load_start and rd_req in the same cycle → no rd_valid, rd_ready = 0, load_count = 0.
- Reset mid-load: drop clr after 2 bytes → load_count = 0 and state LOAD immediately; a reload of 4 bytes then reads correctly.
